// File: rtl/jk_counter_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_counter_driver
// Description : Command-driven up/down counter built from JK-style state bits.
//               A next-value MUX (hold / load / up-step / down-step) is turned
//               into per-bit J/K excitation, which is then applied with full
//               JK semantics (set / clear / hold / toggle).
// Revision    : 1.0 - initial release
// ============================================================================
module jk_counter_driver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [1:0] c_OP_LOAD = 2'b00;
    localparam logic [1:0] c_OP_UP   = 2'b01;
    localparam logic [1:0] c_OP_DOWN = 2'b10;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO = {WIDTH{1'b0}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_target;
    logic             r_dir_down;
    logic             r_wrap;

    logic             w_accept;
    logic             w_step;
    logic             w_wrap_next;
    logic             w_latch;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_q_next;

    // Ready is purely a function of state; forced low while reset is held.
    assign cmd_ready = (r_state == c_ST_IDLE) && reset;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_step    = (r_state == c_ST_RUN) && en && !abort;
    assign w_latch   = w_accept && ((cmd_op == c_OP_UP) || (cmd_op == c_OP_DOWN));

    // Next-value MUX: load, up-step, down-step, otherwise hold.
    always_comb begin
        w_nxt = r_q;
        if (w_accept && (cmd_op == c_OP_LOAD)) begin
            w_nxt = cmd_data;
        end else if (w_step) begin
            w_nxt = r_dir_down ? (r_q - c_ONE) : (r_q + c_ONE);
        end
    end

    // Excitation derived from the desired transition of each bit.
    assign w_j = w_nxt & ~r_q;
    assign w_k = r_q & ~w_nxt;

    // Full JK update per bit, including toggle for j=k=1.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_jk_bit
            assign w_q_next[i] = (w_j[i] & w_k[i])  ? ~r_q[i] :
                                 (w_j[i] & ~w_k[i]) ? 1'b1    :
                                 (~w_j[i] & w_k[i]) ? 1'b0    : r_q[i];
        end
    endgenerate

    // Wrap is flagged when a step crosses between the two extremes.
    assign w_wrap_next = w_step && (r_dir_down ? (r_q == c_ZERO) : (r_q == c_MAX));

    // Next-state logic; abort outranks both enable and target match.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_latch) begin
                    w_state_next = (cmd_data == r_q) ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (abort) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_step && (w_nxt == r_target)) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // State, counter bits and wrap pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_q     <= c_ZERO;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_wrap  <= w_wrap_next;
        end
    end

    // Target and direction captured when a count command is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_target   <= c_ZERO;
            r_dir_down <= 1'b0;
        end else if (w_latch) begin
            r_target   <= cmd_data;
            r_dir_down <= (cmd_op == c_OP_DOWN);
        end
    end

    assign q     = r_q;
    assign qbar  = ~r_q;
    assign j_vec = w_j;
    assign k_vec = w_k;
    assign busy  = (r_state == c_ST_RUN);
    assign done  = (r_state == c_ST_DONE);
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_jk_counter_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_counter_driver
// Description : Directed self-checking bench for jk_counter_driver (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_counter_driver;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       en;
    logic       abort;
    logic [3:0] q;
    logic [3:0] qbar;
    logic [3:0] j_vec;
    logic [3:0] k_vec;
    logic       busy;
    logic       done;
    logic       wrap;

    int checks;
    int errors;

    jk_counter_driver #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .en(en), .abort(abort),
        .q(q), .qbar(qbar), .j_vec(j_vec), .k_vec(k_vec),
        .busy(busy), .done(done), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_value(input logic [3:0] v);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = v;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (q !== v) begin errors++; $display("FAIL load_value q=%0d expected %0d", q, v); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if (q !== 4'h0 || qbar !== 4'hF) begin
            errors++; $display("FAIL reset_q q=%h qbar=%h expected 0/F", q, qbar);
        end
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
            errors++; $display("FAIL reset_flags rdy=%b busy=%b done=%b wrap=%b expected 0000",
                               cmd_ready, busy, done, wrap);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release cmd_ready=%b expected 1", cmd_ready); end
    endtask

    task automatic test_load();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'd3;
        #1;
        checks++;
        if (j_vec !== 4'b0011 || k_vec !== 4'b0000) begin
            errors++; $display("FAIL load_jk j=%b k=%b expected 0011/0000", j_vec, k_vec);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (q !== 4'd3 || done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL load q=%0d done=%b rdy=%b busy=%b expected 3/0/1/0", q, done, cmd_ready, busy);
        end
    endtask

    task automatic test_count_up();
        logic [3:0] exp_q;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'd7; en = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (q !== 4'd3 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL up_accept q=%0d busy=%b rdy=%b expected 3/1/0", q, busy, cmd_ready);
        end
        checks++;
        if (j_vec !== 4'b0100 || k_vec !== 4'b0011) begin
            errors++; $display("FAIL up_jk j=%b k=%b expected 0100/0011", j_vec, k_vec);
        end
        for (int s = 1; s <= 4; s++) begin
            tick();
            exp_q = 4'd3 + 4'(s);
            checks++;
            if (q !== exp_q || done !== (s == 4)) begin
                errors++; $display("FAIL up_step%0d q=%0d done=%b expected %0d/%b", s, q, done, exp_q, (s == 4));
            end
        end
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL up_done_rdy cmd_ready=%b expected 0", cmd_ready); end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || q !== 4'd7) begin
            errors++; $display("FAIL up_idle rdy=%b done=%b q=%0d expected 1/0/7", cmd_ready, done, q);
        end
    endtask

    task automatic test_count_down_wrap();
        logic [3:0] exp_q [3];
        logic       exp_w [3];
        exp_q[0] = 4'd0;  exp_q[1] = 4'd15; exp_q[2] = 4'd14;
        exp_w[0] = 1'b0;  exp_w[1] = 1'b1;  exp_w[2] = 1'b0;
        load_value(4'd1);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 4'd14; en = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (q !== exp_q[s] || wrap !== exp_w[s] || done !== (s == 2)) begin
                errors++; $display("FAIL down_step%0d q=%0d wrap=%b done=%b expected %0d/%b/%b",
                                   s, q, wrap, done, exp_q[s], exp_w[s], (s == 2));
            end
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || wrap !== 1'b0) begin
            errors++; $display("FAIL down_idle rdy=%b done=%b wrap=%b expected 1/0/0", cmd_ready, done, wrap);
        end
    endtask

    task automatic test_pause_abort();
        load_value(4'd0);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'd9; en = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (q !== 4'd3) begin errors++; $display("FAIL pause_pre q=%0d expected 3", q); end
        en = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (j_vec !== 4'b0 || k_vec !== 4'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL pause_jk%0d j=%b k=%b busy=%b expected 0000/0000/1", s, j_vec, k_vec, busy);
            end
            tick();
            checks++;
            if (q !== 4'd3) begin errors++; $display("FAIL pause_q%0d q=%0d expected 3", s, q); end
        end
        en = 1'b1;
        tick(); tick();
        checks++;
        if (q !== 4'd5 || busy !== 1'b1) begin errors++; $display("FAIL resume q=%0d busy=%b expected 5/1", q, busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (q !== 4'd5 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL abort q=%0d busy=%b rdy=%b done=%b expected 5/0/1/0", q, busy, cmd_ready, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || q !== 4'd5) begin errors++; $display("FAIL abort_after done=%b q=%0d expected 0/5", done, q); end
    endtask

    task automatic test_reset_mid_run();
        load_value(4'd0);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'd12; en = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int s = 0; s < 6; s++) tick();
        checks++;
        if (q !== 4'd6 || busy !== 1'b1) begin errors++; $display("FAIL midrun_pre q=%0d busy=%b expected 6/1", q, busy); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (q !== 4'd0 || qbar !== 4'hF || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL midrun_reset q=%0d qbar=%h busy=%b rdy=%b expected 0/F/0/0", q, qbar, busy, cmd_ready);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL midrun_release rdy=%b done=%b expected 1/0", cmd_ready, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || q !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrun_after done=%b q=%0d busy=%b expected 0/0/0", done, q, busy);
        end
    endtask

    task automatic test_edge_cmds();
        load_value(4'd5);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'd5; en = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || q !== 4'd5 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_step done=%b q=%0d busy=%b expected 1/5/0", done, q, busy);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_step_idle rdy=%b done=%b expected 1/0", cmd_ready, done); end
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'd9;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (q !== 4'd5 || cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reserved q=%0d rdy=%b done=%b busy=%b expected 5/1/0/0", q, cmd_ready, done, busy);
        end
        // Count 5->7, then hold a LOAD 0 valid through RUN and DONE.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'd7;
        tick();
        cmd_op = 2'b00; cmd_data = 4'd0;
        tick();
        checks++;
        if (q !== 4'd6 || busy !== 1'b1) begin errors++; $display("FAIL held_run q=%0d busy=%b expected 6/1", q, busy); end
        tick();
        checks++;
        if (q !== 4'd7 || done !== 1'b1) begin errors++; $display("FAIL held_done q=%0d done=%b expected 7/1", q, done); end
        tick();
        checks++;
        if (q !== 4'd7 || cmd_ready !== 1'b1) begin errors++; $display("FAIL held_idle q=%0d rdy=%b expected 7/1", q, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (q !== 4'd0) begin errors++; $display("FAIL held_accept q=%0d expected 0", q); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0;
        en = 1'b0; abort = 1'b0;
        #2;
        test_reset();
        test_load();
        test_count_up();
        test_count_down_wrap();
        test_pause_abort();
        test_reset_mid_run();
        test_edge_cmds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
